// File: rtl/edge_capture_ctrl.sv
// Edge-time capture sequencer: settle delay, N-edge record window, watchdog timeout.
// All outputs registered; config latched at accepted start.
module edge_capture_ctrl #(
  parameter int SETTLE_W  = 16,
  parameter int COUNT_W   = 16,
  parameter int TIMEOUT_W = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SETTLE_W-1:0]  settle_cycles,
  input  logic [COUNT_W-1:0]   num_edges,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 meas_level,
  output logic                 record_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [COUNT_W-1:0]   edge_count,
  output logic [TIMEOUT_W-1:0] cycles_elapsed
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 meas_prev_q, meas_prev_d;
  logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [COUNT_W-1:0]   num_edges_q, num_edges_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic                 record_enable_q, record_enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timed_out_q, timed_out_d;
  logic [COUNT_W-1:0]   edge_count_q, edge_count_d;
  logic [TIMEOUT_W-1:0] cycles_elapsed_q, cycles_elapsed_d;

  logic                 rise;
  logic [COUNT_W-1:0]   edge_inc;
  logic [TIMEOUT_W-1:0] cyc_inc;

  assign rise     = meas_level & ~meas_prev_q;
  assign edge_inc = edge_count_q + COUNT_W'(1);
  assign cyc_inc  = (cycles_elapsed_q == '1) ? cycles_elapsed_q
                                             : cycles_elapsed_q + TIMEOUT_W'(1);

  always_comb begin
    state_d          = state_q;
    meas_prev_d      = meas_level;
    settle_cnt_d     = settle_cnt_q;
    num_edges_d      = num_edges_q;
    timeout_d        = timeout_q;
    record_enable_d  = record_enable_q;
    busy_d           = busy_q;
    done_d           = done_q;
    timed_out_d      = timed_out_q;
    edge_count_d     = edge_count_q;
    cycles_elapsed_d = cycles_elapsed_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_d     = ST_IDLE;
          done_d      = 1'b0;
          timed_out_d = 1'b0;
        end else if (start) begin
          num_edges_d      = num_edges;
          timeout_d        = timeout_cycles;
          edge_count_d     = '0;
          cycles_elapsed_d = '0;
          done_d           = 1'b0;
          timed_out_d      = 1'b0;
          if (num_edges == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (settle_cycles == '0) begin
            state_d         = ST_CAPTURE;
            record_enable_d = 1'b1;
            busy_d          = 1'b1;
          end else begin
            state_d      = ST_SETTLE;
            settle_cnt_d = settle_cycles;
            busy_d       = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
          if (settle_cnt_q <= SETTLE_W'(1)) begin
            state_d         = ST_CAPTURE;
            record_enable_d = 1'b1;
          end
        end
      end

      ST_CAPTURE: begin
        if (abort) begin
          // Counters are left untouched so software can inspect the partial run.
          state_d         = ST_IDLE;
          record_enable_d = 1'b0;
          busy_d          = 1'b0;
        end else begin
          cycles_elapsed_d = cyc_inc;
          if (rise) edge_count_d = edge_inc;
          // The final edge takes priority over a coincident timeout.
          if (rise && (edge_inc == num_edges_q)) begin
            state_d         = ST_DONE;
            record_enable_d = 1'b0;
            busy_d          = 1'b0;
            done_d          = 1'b1;
            timed_out_d     = 1'b0;
          end else if ((timeout_q != '0) && (cyc_inc == timeout_q)) begin
            state_d         = ST_DONE;
            record_enable_d = 1'b0;
            busy_d          = 1'b0;
            done_d          = 1'b1;
            timed_out_d     = 1'b1;
          end
        end
      end

      default: begin
        state_d         = ST_IDLE;
        record_enable_d = 1'b0;
        busy_d          = 1'b0;
        done_d          = 1'b0;
        timed_out_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      meas_prev_q      <= 1'b0;
      settle_cnt_q     <= '0;
      num_edges_q      <= '0;
      timeout_q        <= '0;
      record_enable_q  <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      timed_out_q      <= 1'b0;
      edge_count_q     <= '0;
      cycles_elapsed_q <= '0;
    end else begin
      state_q          <= state_d;
      meas_prev_q      <= meas_prev_d;
      settle_cnt_q     <= settle_cnt_d;
      num_edges_q      <= num_edges_d;
      timeout_q        <= timeout_d;
      record_enable_q  <= record_enable_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      timed_out_q      <= timed_out_d;
      edge_count_q     <= edge_count_d;
      cycles_elapsed_q <= cycles_elapsed_d;
    end
  end

  assign record_enable  = record_enable_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timed_out      = timed_out_q;
  assign edge_count     = edge_count_q;
  assign cycles_elapsed = cycles_elapsed_q;

endmodule

// File: tb/tb_edge_capture_ctrl.sv
// Directed bench for edge_capture_ctrl: hand-computed expectations per clock step.
module tb_edge_capture_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] settle_cycles = '0;
  logic [15:0] num_edges = '0;
  logic [19:0] timeout_cycles = '0;
  logic        meas_level = 1'b0;
  logic        record_enable, busy, done, timed_out;
  logic [15:0] edge_count;
  logic [19:0] cycles_elapsed;

  int tests = 0;
  int fails = 0;

  edge_capture_ctrl #(.SETTLE_W(16), .COUNT_W(16), .TIMEOUT_W(20)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .settle_cycles(settle_cycles), .num_edges(num_edges),
    .timeout_cycles(timeout_cycles), .meas_level(meas_level),
    .record_enable(record_enable), .busy(busy), .done(done),
    .timed_out(timed_out), .edge_count(edge_count),
    .cycles_elapsed(cycles_elapsed)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive meas_level, take one rising edge, then settle 1ns past it.
  task automatic tick(input logic m);
    meas_level = m;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic re, input logic bz, input logic dn,
                           input logic to, input int ec, input int cyc);
    check({tag, ".record_enable"}, 32'(record_enable), 32'(re));
    check({tag, ".busy"},          32'(busy),          32'(bz));
    check({tag, ".done"},          32'(done),          32'(dn));
    check({tag, ".timed_out"},     32'(timed_out),     32'(to));
    check({tag, ".edge_count"},    32'(edge_count),    32'(ec));
    check({tag, ".cycles"},        32'(cycles_elapsed), 32'(cyc));
  endtask

  initial begin
    // Reset state
    #3;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    tick(0); tick(0);
    reset = 1'b0;
    tick(0);
    check_all("idle", 0, 0, 0, 0, 0, 0);

    // Nominal: settle 4, 3 edges, no timeout; a rise during settle is ignored
    settle_cycles = 16'd4; num_edges = 16'd3; timeout_cycles = 20'd0;
    start = 1'b1; tick(0); start = 1'b0;
    check_all("nom_t0", 0, 1, 0, 0, 0, 0);
    tick(1); tick(1); tick(0);
    check("nom_settle_re", 32'(record_enable), 32'd0);
    tick(0);
    check_all("nom_open", 1, 1, 0, 0, 0, 0);
    tick(1);
    check_all("nom_e1", 1, 1, 0, 0, 1, 1);
    tick(1); tick(0); tick(0); tick(1); tick(1); tick(0); tick(0);
    check_all("nom_e2", 1, 1, 0, 0, 2, 8);
    tick(1);
    check_all("nom_done", 0, 0, 1, 0, 3, 9);
    tick(0); tick(1);
    check_all("nom_hold", 0, 0, 1, 0, 3, 9);

    // Timeout, restarted from DONE; config changed after start must not matter
    settle_cycles = 16'd2; num_edges = 16'd5; timeout_cycles = 20'd10;
    start = 1'b1; tick(0); start = 1'b0;
    num_edges = 16'd1; timeout_cycles = 20'd0; settle_cycles = 16'd9;
    check_all("to_restart", 0, 1, 0, 0, 0, 0);
    tick(0); tick(0);
    check_all("to_open", 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick(0);
    check_all("to_c9", 1, 1, 0, 0, 0, 9);
    tick(0);
    check_all("to_done", 0, 0, 1, 1, 0, 10);
    abort = 1'b1; tick(0); abort = 1'b0;
    check_all("to_abort_done", 0, 0, 0, 0, 0, 10);

    // Edge and timeout on the same cycle: edge wins
    settle_cycles = 16'd0; num_edges = 16'd1; timeout_cycles = 20'd3;
    start = 1'b1; tick(0); start = 1'b0;
    check_all("tie_open", 1, 1, 0, 0, 0, 0);
    tick(0); tick(0); tick(1);
    check_all("tie_done", 0, 0, 1, 0, 1, 3);

    // num_edges = 0 goes straight to DONE
    abort = 1'b1; tick(0); abort = 1'b0;
    check("zero_pre_done", 32'(done), 32'd0);
    settle_cycles = 16'd3; num_edges = 16'd0; timeout_cycles = 20'd0;
    start = 1'b1; tick(0); start = 1'b0;
    check_all("zero_n", 0, 0, 1, 0, 0, 0);
    abort = 1'b1; tick(0); abort = 1'b0;

    // Abort mid-capture at edge_count 2; start while busy ignored
    settle_cycles = 16'd0; num_edges = 16'd5; timeout_cycles = 20'd0;
    start = 1'b1; tick(0); start = 1'b0;
    tick(1);
    start = 1'b1; tick(0); start = 1'b0;
    check_all("busy_start", 1, 1, 0, 0, 1, 2);
    tick(1);
    check_all("ab_e2", 1, 1, 0, 0, 2, 3);
    abort = 1'b1; tick(0); abort = 1'b0;
    check_all("ab_idle", 0, 0, 0, 0, 2, 3);
    start = 1'b1; abort = 1'b1; tick(0); start = 1'b0; abort = 1'b0;
    check_all("ab_start", 0, 0, 0, 0, 2, 3);

    // Async reset between edges mid-capture
    start = 1'b1; tick(0); start = 1'b0;
    tick(1);
    check_all("rst_pre", 1, 1, 0, 0, 1, 1);
    #2 reset = 1'b1;
    #1;
    check_all("rst_async", 0, 0, 0, 0, 0, 0);
    tick(0);
    #2 reset = 1'b0;
    settle_cycles = 16'd1; num_edges = 16'd1; timeout_cycles = 20'd0;
    start = 1'b1; tick(0); start = 1'b0;
    check_all("rst_new_t0", 0, 1, 0, 0, 0, 0);
    tick(0);
    check_all("rst_new_open", 1, 1, 0, 0, 0, 0);
    tick(1);
    check_all("rst_new_done", 0, 0, 1, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/edge_capture_ctrl.md
Name: edge_capture_ctrl

Overview:
- Sequencer for PLL edge-time measurement: on `start`, waits a programmable settle interval, then asserts `record_enable` for a window of N rising edges of the monitored clock, then reports completion.
- `record_enable` drives the enable of the edge recorder.
- Includes a watchdog timeout so a dead or unlocked oscillator cannot hang the capture.
- Runs on the reference clock. The monitored clock arrives already synchronized as a level (`meas_level`).

Parameters:
- SETTLE_W, 16, width of the settle-cycle count
- COUNT_W, 16, width of the edge target and `edge_count`
- TIMEOUT_W, 20, width of the timeout limit and `cycles_elapsed`

Ports:
- clock  in  1  reference clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin capture; sampled in IDLE or DONE
- abort  in  1  cancel; overrides `start`
- settle_cycles  in  SETTLE_W  cycles to wait before the window opens
- num_edges  in  COUNT_W  rising edges to capture
- timeout_cycles  in  TIMEOUT_W  capture-window cycle limit; 0 disables the timeout
- meas_level  in  1  synchronized monitored clock level
- record_enable  out  1  gates the edge recorder
- busy  out  1  high in SETTLE or CAPTURE
- done  out  1  level, high in DONE
- timed_out  out  1  level, high in DONE when the capture ended by timeout
- edge_count  out  COUNT_W  edges captured in the current/last run
- cycles_elapsed  out  TIMEOUT_W  CAPTURE cycles in the current/last run; saturates at all-ones

Behaviour:
- Reset (async assert):
  - state = IDLE; all outputs 0; `meas_prev` = 0; settle counter = 0.
- All outputs are registered.
- Config inputs are latched when `start` is accepted. Later changes have no effect until the next start.
- Edge detect: `rise = meas_level & ~meas_prev`. `meas_prev` updates every cycle in every state. Only `rise` observed in CAPTURE is counted.
- IDLE:
  - `start & ~abort` clears `edge_count`, `cycles_elapsed`, `done` and `timed_out`, then transitions:
    - `num_edges` == 0 → DONE;
    - else `settle_cycles` == 0 → CAPTURE;
    - else → SETTLE with the counter loaded to `settle_cycles`.
- SETTLE:
  - Counter decrements each cycle.
  - At counter == 1 → CAPTURE.
  - With start accepted at edge t0, `record_enable` is first high after edge t0+S (S = `settle_cycles`). For S = 0 it is high after t0.
- CAPTURE:
  - `record_enable` = 1.
  - Each cycle: `cycles_elapsed` += 1, saturating.
  - Each `rise`: `edge_count` += 1.
  - When `edge_count` reaches `num_edges` → DONE with `timed_out` = 0.
  - Else, if `timeout_cycles` != 0 and the incremented `cycles_elapsed` == `timeout_cycles` → DONE with `timed_out` = 1.
  - Final edge and timeout in the same cycle: the edge wins, so `done` = 1 and `timed_out` = 0.
  - On leaving CAPTURE, `record_enable` drops on the same edge that raises `done`.
- DONE:
  - `done` = 1; counters hold.
  - `start & ~abort` restarts exactly as from IDLE.
  - `abort` → IDLE with `done` and `timed_out` cleared.
- `abort` in SETTLE or CAPTURE → IDLE on the next edge; `record_enable` and `busy` drop. `edge_count` and `cycles_elapsed` hold for inspection.
- `abort` and `start` together: `abort` wins and `start` is ignored.
- `start` while `busy` is ignored.
- `edge_count` never exceeds `num_edges`.
- Reset mid-operation: immediate return to the reset state. No partial `done`.

Test Plan:
- Nominal run: `settle_cycles`=4, `num_edges`=3, `timeout_cycles`=0, `meas_level` toggling every 2 cycles.
  → `record_enable` high from cycle 4 after start until the 3rd counted rise; then `done`=1, `timed_out`=0, `edge_count`=3. No rise during settle is counted.
- Timeout: `num_edges`=5, `timeout_cycles`=10, `meas_level` held 0.
  → After 10 CAPTURE cycles: `done`=1, `timed_out`=1, `edge_count`=0, `cycles_elapsed`=10, `record_enable`=0.
- Edge/timeout tie: `num_edges`=1, `timeout_cycles`=3, rise landing on the 3rd CAPTURE cycle.
  → `done`=1, `timed_out`=0, `edge_count`=1.
- Zero cases: `num_edges`=0 → DONE one cycle after start, `record_enable` never high. `settle_cycles`=0 → `record_enable` high the cycle after start.
- Abort/start priority: `abort` mid-CAPTURE at `edge_count`=2 → IDLE next cycle, `edge_count` holds 2, `done`=0. Simultaneous `start` + `abort` in IDLE → stays IDLE. `start` in DONE → counters cleared and a new run begins.
- Async reset asserted mid-CAPTURE between clock edges → all outputs 0 immediately. After release, a new start runs normally.
